md_unit: RTL and testbench

- Iterative multiply/divide controller in the EX stage; owns the HI/LO registers.
- Executes MULT, MULTU, DIV and DIVU over a fixed number of cycles, with one shift-add / shift-subtract step per cycle.
- Raises busy so the hazard unit stalls the pipeline. Handles MTHI/MTLO writes and abort on pipeline flush.
- The main ALU stays single-cycle; MFHI/MFLO values are read directly from the hi/lo outputs.

---
 rtl/md_unit.sv | 169 ++++++++++++++++
 tb/tb_md_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | md_unit: iterative MULT/MULTU/DIV/DIVU engine that owns HI/LO.         |
// | Optional macro: MD_EARLY_OUT_EN (multiply stops once multiplier is 0). |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module md_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hilo_we,
    input  logic             hilo_sel,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int              CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   C_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_CALC = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_a, r_b, r_y, r_hi, r_lo;
    logic [1:0]           r_op;
    logic [2*WIDTH-1:0]   r_acc, r_x;
    logic [CW-1:0]        r_cnt;
    logic                 r_neg_q, r_neg_r, r_divz, r_done;

    logic                 w_is_div, w_signed, w_neg_a, w_neg_b;
    logic [WIDTH-1:0]     w_abs_a, w_abs_b;
    logic [WIDTH:0]       w_rem_sh, w_diff;
    logic [2*WIDTH-1:0]   w_div_next, w_mul_next, w_prod;
    logic [WIDTH-1:0]     w_quo, w_rem;
    logic                 w_calc_last, w_prep_skip;

    assign w_is_div = r_op[1];
    assign w_signed = ~r_op[0];
    assign w_neg_a  = w_signed & r_a[WIDTH-1];
    assign w_neg_b  = w_signed & r_b[WIDTH-1];
    // The most negative value negates to itself, which read as unsigned is the correct magnitude.
    assign w_abs_a  = w_neg_a ? -r_a : r_a;
    assign w_abs_b  = w_neg_b ? -r_b : r_b;

    // Restoring divide: remainder in the upper half, quotient bits enter at the bottom.
    assign w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_diff     = w_rem_sh - {1'b0, r_y};
    assign w_div_next = w_diff[WIDTH] ? {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                      : {w_diff[WIDTH-1:0],   r_acc[WIDTH-2:0], 1'b1};

    // Multiply accumulates a left-shifting multiplicand so a partial product is always final.
    assign w_mul_next = r_y[0] ? (r_acc + r_x) : r_acc;

    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

`ifdef MD_EARLY_OUT_EN
    assign w_calc_last = (r_cnt == C_LAST) || (!w_is_div && (r_y[WIDTH-1:1] == '0));
    assign w_prep_skip = !w_is_div && (w_abs_b == '0);
`else
    assign w_calc_last = (r_cnt == C_LAST);
    assign w_prep_skip = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_y     <= '0;
            r_op    <= '0;
            r_acc   <= '0;
            r_x     <= '0;
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_divz  <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (hilo_we) begin
                        if (hilo_sel) r_hi <= wdata;
                        else          r_lo <= wdata;
                    end
                    if (start && !flush) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_op    <= op;
                        r_state <= S_PREP;
                    end
                end
                S_PREP: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_neg_q <= w_neg_a ^ w_neg_b;
                        r_neg_r <= w_neg_a;
                        r_divz  <= w_is_div && (r_b == '0);
                        r_cnt   <= '0;
                        r_y     <= w_abs_b;
                        if (w_is_div) begin
                            r_acc <= {{WIDTH{1'b0}}, w_abs_a};
                            r_x   <= '0;
                        end else begin
                            r_acc <= '0;
                            r_x   <= {{WIDTH{1'b0}}, w_abs_a};
                        end
                        if ((w_is_div && (r_b == '0)) || w_prep_skip) r_state <= S_FIX;
                        else                                          r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        if (w_is_div) begin
                            r_acc <= w_div_next;
                        end else begin
                            r_acc <= w_mul_next;
                            r_x   <= r_x << 1;
                            r_y   <= r_y >> 1;
                        end
                        r_cnt <= r_cnt + 1'b1;
                        if (w_calc_last) r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (r_divz) begin
                        r_hi <= r_a;
                        r_lo <= '1;
                    end else if (w_is_div) begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end else begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_md_unit: table, hand sequences and random ops against a model.      |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_md_unit;
    logic        clk = 1'b0;
    logic        rst, start, flush, hilo_we, hilo_sel;
    logic [1:0]  op;
    logic [31:0] a, b, wdata, hi, lo;
    logic        busy, done;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_hi, m_lo;

    md_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .hilo_we(hilo_we), .hilo_sel(hilo_sel), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference results from plain 64-bit arithmetic; returns {hi, lo}.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] xa, input logic [31:0] xb);
        longint sa, sb, p, q, r;
        logic [63:0] up;
        case (o)
            2'd0: begin
                p = longint'($signed(xa)) * longint'($signed(xb));
                return p;
            end
            2'd1: begin
                up = {32'd0, xa} * {32'd0, xb};
                return up;
            end
            default: begin
                if (xb == 32'd0) return {xa, 32'hFFFF_FFFF};
                if (o == 2'd2) begin
                    sa = longint'($signed(xa));
                    sb = longint'($signed(xb));
                end else begin
                    sa = longint'({32'd0, xa});
                    sb = longint'({32'd0, xb});
                end
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    // Cycles from the start edge to the cycle showing done.
    function automatic int exp_lat(input logic [1:0] o, input logic [31:0] xa, input logic [31:0] xb);
`ifdef MD_EARLY_OUT_EN
        logic [31:0] babs;
        int m;
`endif
        if (o[1]) return (xb == 32'd0) ? 3 : 35;
`ifdef MD_EARLY_OUT_EN
        babs = (!o[0] && xb[31]) ? -xb : xb;
        if (babs == 32'd0) return 3;
        m = 0;
        for (int i = 0; i < 32; i++) if (babs[i]) m = i;
        return m + 4;
`else
        if (xa === 32'hx) return 0;
        return 35;
`endif
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] xa, input logic [31:0] xb,
                          input bit noise, input bit wr_hi, input int flush_k, input logic [63:0] exp);
        int lat, k;
        bit busy_ok, abort, saw_done;
        logic [31:0] wv;
        lat   = exp_lat(o, xa, xb);
        abort = (flush_k > 0) && (flush_k <= lat - 2);
        wv    = $urandom;
        op = o; a = xa; b = xb; start = 1'b1;
        if (wr_hi) begin
            hilo_we = 1'b1; hilo_sel = 1'b1; wdata = wv; m_hi = wv;
        end
        tick();
        start = 1'b0; hilo_we = 1'b0;
        busy_ok = 1'b1;
        k = 1;
        while (k < 100 && done !== 1'b1 && !(abort && k > flush_k)) begin
            if (busy !== 1'b1 || hi !== m_hi || lo !== m_lo) busy_ok = 1'b0;
            flush = (k == flush_k);
            if (noise && k >= 2 && k <= lat - 3) begin
                start = 1'b1; hilo_we = 1'b1;
                hilo_sel = 1'($urandom_range(0, 1));
                wdata = $urandom; a = $urandom; b = $urandom;
                op = 2'($urandom_range(0, 3));
            end else begin
                start = 1'b0; hilo_we = 1'b0;
            end
            tick();
            k++;
        end
        flush = 1'b0; start = 1'b0; hilo_we = 1'b0;
        chk("busy_window", {63'd0, busy_ok}, 64'd1);
        if (abort) begin
            chk("abort_idle", {63'd0, busy}, 64'd0);
            saw_done = 1'b0;
            for (int i = 0; i < 40; i++) begin
                if (done === 1'b1) saw_done = 1'b1;
                tick();
            end
            chk("abort_no_done", {63'd0, saw_done}, 64'd0);
            chk("abort_hold", {hi, lo}, {m_hi, m_lo});
        end else begin
            chk("latency", 64'(k), 64'(lat));
            chk("result", {hi, lo}, exp);
            m_hi = exp[63:32];
            m_lo = exp[31:0];
            tick();
            chk("done_pulse_idle", {62'd0, done, busy}, 64'd0);
        end
    endtask

    vec_t tbl[9];

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; hilo_we = 1'b0; hilo_sel = 1'b0;
        op = 2'd0; a = '0; b = '0; wdata = '0;
        tbl[0] = '{2'd0, 32'hFFFF_FFFE, 32'd3,          32'hFFFF_FFFF, 32'hFFFF_FFFA};
        tbl[1] = '{2'd1, 32'hFFFF_FFFE, 32'd3,          32'h0000_0002, 32'hFFFF_FFFA};
        tbl[2] = '{2'd2, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tbl[3] = '{2'd3, 32'd7,         32'd2,          32'd1,         32'd3};
        tbl[4] = '{2'd3, 32'h0000_1234, 32'd0,          32'h0000_1234, 32'hFFFF_FFFF};
        tbl[5] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         32'h8000_0000};
        tbl[6] = '{2'd2, 32'h8000_0000, 32'd0,          32'h8000_0000, 32'hFFFF_FFFF};
        tbl[7] = '{2'd0, 32'h8000_0000, 32'h8000_0000,  32'h4000_0000, 32'd0};
        tbl[8] = '{2'd1, 32'd5,         32'd0,          32'd0,         32'd0};

        tick(); tick();
        chk("reset_state", {30'd0, busy, done, hi, lo}, 64'd0);
        rst = 1'b0;
        m_hi = '0; m_lo = '0;

        // MTHI / MTLO in IDLE.
        hilo_we = 1'b1; hilo_sel = 1'b1; wdata = 32'hDEAD_BEEF; tick();
        hilo_sel = 1'b0; wdata = 32'h1234_5678; tick();
        hilo_we = 1'b0;
        m_hi = 32'hDEAD_BEEF; m_lo = 32'h1234_5678;
        chk("mthi_mtlo", {hi, lo}, {m_hi, m_lo});

        // flush in IDLE cancels a same-cycle start.
        start = 1'b1; flush = 1'b1; op = 2'd0; a = 32'd3; b = 32'd4; tick();
        start = 1'b0; flush = 1'b0;
        chk("idle_flush_cancel", {63'd0, busy}, 64'd0);

        for (int i = 0; i < 9; i++)
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, 1'b0, 1'b0, 0, {tbl[i].ehi, tbl[i].elo});

        // Flush at CALC cycle 10 aborts; flush in FIX is ignored.
        run_op(2'd0, 32'h1357_9BDF, 32'h7FFF_FFFF, 1'b0, 1'b0, 12, 64'd0);
        run_op(2'd3, 32'd100, 32'd7, 1'b0, 1'b0, 34, {32'd2, 32'd14});
        // MTHI together with start, then busy-time start/hilo_we noise.
        run_op(2'd3, 32'd7, 32'd2, 1'b0, 1'b1, 0, {32'd1, 32'd3});
        run_op(2'd1, 32'd5, 32'hF000_0007, 1'b1, 1'b0, 0, model(2'd1, 32'd5, 32'hF000_0007));

        // Reset mid-operation clears HI/LO.
        start = 1'b1; op = 2'd0; a = 32'h0000_0777; b = 32'hFFFF_0001; tick();
        start = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        m_hi = '0; m_lo = '0;
        chk("rst_midop", {30'd0, busy, done, hi, lo}, 64'd0);
        tick();
        chk("rst_stays_idle", {62'd0, busy, done}, 64'd0);

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = rb >> $urandom_range(1, 31);
                2: ra = 32'h8000_0000;
                3: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_op(ro, ra, rb, 1'($urandom_range(0, 1)), 1'b0, 0, model(ro, ra, rb));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
